// File: rtl/risc8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc8_pkg
// Description : Shared constants and types for the risc8 5-stage pipeline:
//               opcodes, ALU operations, forward selects, instruction fields.
// Revision    : 1.0 - initial release
// ============================================================================
package risc8_pkg;

    // Opcodes (instruction bits [15:12]); E and F decode as NOP
    localparam logic [3:0] c_op_nop  = 4'h0;
    localparam logic [3:0] c_op_add  = 4'h1;
    localparam logic [3:0] c_op_sub  = 4'h2;
    localparam logic [3:0] c_op_and  = 4'h3;
    localparam logic [3:0] c_op_or   = 4'h4;
    localparam logic [3:0] c_op_xor  = 4'h5;
    localparam logic [3:0] c_op_shl  = 4'h6;
    localparam logic [3:0] c_op_shr  = 4'h7;
    localparam logic [3:0] c_op_addi = 4'h8;
    localparam logic [3:0] c_op_ld   = 4'h9;
    localparam logic [3:0] c_op_st   = 4'hA;
    localparam logic [3:0] c_op_beq  = 4'hB;
    localparam logic [3:0] c_op_bne  = 4'hC;
    localparam logic [3:0] c_op_jmp  = 4'hD;

    // Instruction field positions
    localparam int c_op_msb  = 15;
    localparam int c_op_lsb  = 12;
    localparam int c_rd_msb  = 11;
    localparam int c_rd_lsb  = 9;
    localparam int c_rs1_msb = 8;
    localparam int c_rs1_lsb = 6;
    localparam int c_rs2_msb = 5;
    localparam int c_rs2_lsb = 3;
    localparam int c_imm_msb = 5;
    localparam int c_tgt_msb = 7;

    // ALU operations; ALU_ADD is zero so an all-zero pipeline slot is a NOP
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6
    } alu_op_e;

    // Operand forward selects
    localparam logic [1:0] c_fwd_rf  = 2'b00;
    localparam logic [1:0] c_fwd_wb  = 2'b01;
    localparam logic [1:0] c_fwd_mem = 2'b10;

    localparam logic [15:0] c_nop_instr = 16'h0000;
    localparam int          c_num_regs  = 8;

    // Decoded control bits carried down the pipeline
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic alusrc;
        logic beq;
        logic bne;
        logic jump;
    } ctrl_t;

    // Sign-extend the 6-bit immediate to the 8-bit datapath
    function automatic logic [7:0] sext6(input logic [5:0] v);
        return {{2{v[5]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc8_regfile.sv
`default_nettype none
// ============================================================================
// Module      : risc8_regfile
// Description : 8x8 register file, two asynchronous read ports, one
//               synchronous write port with write-through bypass; R0 is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module risc8_regfile
    import risc8_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] i_raddr1,
    input  logic [2:0] i_raddr2,
    output logic [7:0] o_rdata1,
    output logic [7:0] o_rdata2,
    input  logic       i_wen,
    input  logic [2:0] i_waddr,
    input  logic [7:0] i_wdata
);

    logic [7:0] regs [0:c_num_regs-1];

    // Register storage; writes to R0 are dropped so it always holds zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_num_regs; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (i_wen && (i_waddr != 3'd0)) begin
            regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports: R0 reads zero, a register being written returns the new value
    always_comb begin
        o_rdata1 = regs[i_raddr1];
        o_rdata2 = regs[i_raddr2];
        if (i_wen && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
        if (i_wen && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
        if (i_raddr1 == 3'd0) o_rdata1 = 8'h00;
        if (i_raddr2 == 3'd0) o_rdata2 = 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/risc8_pipe_top.sv
`default_nettype none
// ============================================================================
// Module      : risc8_pipe_top
// Description : 8-bit 5-stage (IF/ID/EX/MEM/WB) pipelined RISC core with
//               instruction ROM, data RAM, forwarding and hazard handling.
// Revision    : 1.0 - initial release
// ============================================================================
module risc8_pipe_top
    import risc8_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic clk_in,
    input  logic reset_n_in
);

    // Clock buffer and reset synchronizer
    logic clk;
    logic r_rst_meta;
    logic reset_n;

    assign clk = clk_in;

    // Two-flop synchronizer: asserts immediately, releases on the 2nd edge
    always_ff @(posedge clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_rst_meta <= 1'b0;
            reset_n    <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            reset_n    <= r_rst_meta;
        end
    end

    // Pipeline signals
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [15:0] id_instr;
    logic [7:0]  r_id_pc;
    logic [3:0]  opcode;
    logic [2:0]  rs1, rs2, rd;
    logic [2:0]  w_src2;
    logic [7:0]  w_imm, w_rdata1, w_rdata2;
    ctrl_t       w_ctrl;
    alu_op_e     w_aluop;
    logic        w_src2_is_rd, w_uses_rs1, w_uses_src2;
    logic        stall, flush_ifid, branch_taken;

    alu_op_e     ex_aluop;
    logic [2:0]  ex_rd, r_ex_rs1, r_ex_src2;
    logic [7:0]  r_ex_pc, r_ex_a, r_ex_b, r_ex_imm, r_ex_target;
    ctrl_t       r_ex_ctrl;
    logic [1:0]  forwardA, forwardB;
    logic [7:0]  w_op_a, w_op_b, w_alu_b, alu_y_pipe;
    logic [7:0]  w_branch_target, w_next_pc;

    logic [7:0]  mem_alu_y, mem_rd2, w_load_data;
    logic [2:0]  mem_rd;
    logic        mem_memread, mem_memwrite, r_mem_regwrite;
    logic [7:0]  r_dmem [0:DMEM_DEPTH-1];

    logic [2:0]  wb_rd;
    logic        wb_regwrite, r_wb_memread;
    logic [7:0]  r_wb_alu_y, r_wb_load, writeback_data;

    // Default program contents
    function automatic logic [15:0] rom_word(input logic [7:0] addr);
        case (addr)
            8'd0:    rom_word = 16'h8205; // ADDI R1,R0,5
            8'd1:    rom_word = 16'h8403; // ADDI R2,R0,3
            8'd2:    rom_word = 16'h1650; // ADD  R3,R1,R2
            8'd3:    rom_word = 16'h28C8; // SUB  R4,R3,R1
            8'd4:    rom_word = 16'hA602; // ST   R3,[R0+2]
            8'd5:    rom_word = 16'h9A02; // LD   R5,[R0+2]
            8'd6:    rom_word = 16'h1D48; // ADD  R6,R5,R1
            8'd7:    rom_word = 16'hB881; // BEQ  R4,R2,+1
            8'd8:    rom_word = 16'h8E01; // ADDI R7,R0,1
            8'd9:    rom_word = 16'h8E07; // ADDI R7,R0,7
            8'd10:   rom_word = 16'hD00A; // JMP  10
            default: rom_word = c_nop_instr;
        endcase
    endfunction

    // ---------------- IF ----------------
    assign instr     = (int'(pc) < IMEM_DEPTH) ? rom_word(pc) : c_nop_instr;
    assign w_next_pc = r_ex_ctrl.jump ? r_ex_target : w_branch_target;

    // Program counter: redirect on a resolved branch, hold on a load-use stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= 8'h00;
        end else if (branch_taken) begin
            pc <= w_next_pc;
        end else if (!stall) begin
            pc <= pc + 8'd1;
        end
    end

    // IF/ID register: squashed on redirect, frozen on stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_instr <= c_nop_instr;
            r_id_pc  <= 8'h00;
        end else if (flush_ifid) begin
            id_instr <= c_nop_instr;
            r_id_pc  <= 8'h00;
        end else if (!stall) begin
            id_instr <= instr;
            r_id_pc  <= pc;
        end
    end

    // ---------------- ID ----------------
    assign opcode = id_instr[c_op_msb:c_op_lsb];
    assign rd     = id_instr[c_rd_msb:c_rd_lsb];
    assign rs1    = id_instr[c_rs1_msb:c_rs1_lsb];
    assign rs2    = id_instr[c_rs2_msb:c_rs2_lsb];
    assign w_imm  = sext6(id_instr[c_imm_msb:0]);
    assign w_src2 = w_src2_is_rd ? rd : rs2;

    // Decode: control bits, ALU op and which register sources are really read
    always_comb begin
        w_ctrl       = '0;
        w_aluop      = ALU_ADD;
        w_src2_is_rd = 1'b0;
        w_uses_rs1   = 1'b0;
        w_uses_src2  = 1'b0;
        case (opcode)
            c_op_add, c_op_sub, c_op_and, c_op_or,
            c_op_xor, c_op_shl, c_op_shr: begin
                w_ctrl.regwrite = 1'b1;
                w_uses_rs1      = 1'b1;
                w_uses_src2     = 1'b1;
                case (opcode)
                    c_op_sub: w_aluop = ALU_SUB;
                    c_op_and: w_aluop = ALU_AND;
                    c_op_or:  w_aluop = ALU_OR;
                    c_op_xor: w_aluop = ALU_XOR;
                    c_op_shl: w_aluop = ALU_SHL;
                    c_op_shr: w_aluop = ALU_SHR;
                    default:  w_aluop = ALU_ADD;
                endcase
            end
            c_op_addi: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_uses_rs1      = 1'b1;
            end
            c_op_ld: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.memread  = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_uses_rs1      = 1'b1;
            end
            c_op_st: begin
                w_ctrl.memwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_uses_rs1      = 1'b1;
                w_uses_src2     = 1'b1;
                w_src2_is_rd    = 1'b1;
            end
            c_op_beq, c_op_bne: begin
                w_ctrl.beq   = (opcode == c_op_beq);
                w_ctrl.bne   = (opcode == c_op_bne);
                w_uses_rs1   = 1'b1;
                w_uses_src2  = 1'b1;
                w_src2_is_rd = 1'b1;
            end
            c_op_jmp: w_ctrl.jump = 1'b1;
            default:  w_ctrl = '0;
        endcase
    end

    risc8_regfile RF (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_raddr1 (rs1),
        .i_raddr2 (w_src2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_wen    (wb_regwrite),
        .i_waddr  (wb_rd),
        .i_wdata  (writeback_data)
    );

    // Load-use hazard: the ID instruction needs the register a load in EX fills
    assign stall = r_ex_ctrl.memread && (ex_rd != 3'd0) &&
                   ((w_uses_rs1 && (rs1 == ex_rd)) || (w_uses_src2 && (w_src2 == ex_rd)));

    // ID/EX register: a bubble is inserted on redirect or stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_aluop    <= ALU_ADD;
            ex_rd       <= 3'd0;
            r_ex_rs1    <= 3'd0;
            r_ex_src2   <= 3'd0;
            r_ex_pc     <= 8'h00;
            r_ex_a      <= 8'h00;
            r_ex_b      <= 8'h00;
            r_ex_imm    <= 8'h00;
            r_ex_target <= 8'h00;
            r_ex_ctrl   <= '0;
        end else if (flush_ifid || stall) begin
            ex_aluop    <= ALU_ADD;
            ex_rd       <= 3'd0;
            r_ex_rs1    <= 3'd0;
            r_ex_src2   <= 3'd0;
            r_ex_pc     <= 8'h00;
            r_ex_a      <= 8'h00;
            r_ex_b      <= 8'h00;
            r_ex_imm    <= 8'h00;
            r_ex_target <= 8'h00;
            r_ex_ctrl   <= '0;
        end else begin
            ex_aluop    <= w_aluop;
            ex_rd       <= rd;
            r_ex_rs1    <= rs1;
            r_ex_src2   <= w_src2;
            r_ex_pc     <= r_id_pc;
            r_ex_a      <= w_rdata1;
            r_ex_b      <= w_rdata2;
            r_ex_imm    <= w_imm;
            r_ex_target <= id_instr[c_tgt_msb:0];
            r_ex_ctrl   <= w_ctrl;
        end
    end

    // ---------------- EX ----------------
    // Forward selection: EX/MEM first, then MEM/WB, never for R0
    always_comb begin
        forwardA = c_fwd_rf;
        forwardB = c_fwd_rf;
        if (r_mem_regwrite && (mem_rd != 3'd0) && (mem_rd == r_ex_rs1)) begin
            forwardA = c_fwd_mem;
        end else if (wb_regwrite && (wb_rd != 3'd0) && (wb_rd == r_ex_rs1)) begin
            forwardA = c_fwd_wb;
        end
        if (r_mem_regwrite && (mem_rd != 3'd0) && (mem_rd == r_ex_src2)) begin
            forwardB = c_fwd_mem;
        end else if (wb_regwrite && (wb_rd != 3'd0) && (wb_rd == r_ex_src2)) begin
            forwardB = c_fwd_wb;
        end
    end

    // Operand muxes and ALU
    always_comb begin
        case (forwardA)
            c_fwd_mem: w_op_a = mem_alu_y;
            c_fwd_wb:  w_op_a = writeback_data;
            default:   w_op_a = r_ex_a;
        endcase
        case (forwardB)
            c_fwd_mem: w_op_b = mem_alu_y;
            c_fwd_wb:  w_op_b = writeback_data;
            default:   w_op_b = r_ex_b;
        endcase
        w_alu_b = r_ex_ctrl.alusrc ? r_ex_imm : w_op_b;
        case (ex_aluop)
            ALU_SUB: alu_y_pipe = w_op_a - w_alu_b;
            ALU_AND: alu_y_pipe = w_op_a & w_alu_b;
            ALU_OR:  alu_y_pipe = w_op_a | w_alu_b;
            ALU_XOR: alu_y_pipe = w_op_a ^ w_alu_b;
            ALU_SHL: alu_y_pipe = w_op_a << w_alu_b[2:0];
            ALU_SHR: alu_y_pipe = w_op_a >> w_alu_b[2:0];
            default: alu_y_pipe = w_op_a + w_alu_b;
        endcase
    end

    // Branch compares R[rd] (second source) with R[rs1]
    assign w_branch_target = r_ex_pc + 8'd1 + r_ex_imm;
    assign branch_taken    = r_ex_ctrl.jump ||
                             (r_ex_ctrl.beq && (w_op_a == w_op_b)) ||
                             (r_ex_ctrl.bne && (w_op_a != w_op_b));
    assign flush_ifid      = branch_taken;

    // EX/MEM register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_alu_y      <= 8'h00;
            mem_rd2        <= 8'h00;
            mem_rd         <= 3'd0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            r_mem_regwrite <= 1'b0;
        end else begin
            mem_alu_y      <= alu_y_pipe;
            mem_rd2        <= w_op_b;
            mem_rd         <= ex_rd;
            mem_memread    <= r_ex_ctrl.memread;
            mem_memwrite   <= r_ex_ctrl.memwrite;
            r_mem_regwrite <= r_ex_ctrl.regwrite;
        end
    end

    // ---------------- MEM ----------------
    // Data RAM: synchronous write, cleared by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                r_dmem[i] <= 8'h00;
            end
        end else if (mem_memwrite) begin
            r_dmem[mem_alu_y] <= mem_rd2;
        end
    end

    assign w_load_data = r_dmem[mem_alu_y];

    // MEM/WB register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_rd        <= 3'd0;
            wb_regwrite  <= 1'b0;
            r_wb_memread <= 1'b0;
            r_wb_alu_y   <= 8'h00;
            r_wb_load    <= 8'h00;
        end else begin
            wb_rd        <= mem_rd;
            wb_regwrite  <= r_mem_regwrite;
            r_wb_memread <= mem_memread;
            r_wb_alu_y   <= mem_alu_y;
            r_wb_load    <= w_load_data;
        end
    end

    // ---------------- WB ----------------
    assign writeback_data = r_wb_memread ? r_wb_load : r_wb_alu_y;

endmodule
`default_nettype wire

// File: tb/tb_risc8_pipe_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc8_pipe_top
// Description : Self-checking bench for risc8_pipe_top: cycle table for the
//               default program, reset sequences, random reset injection
//               checked against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc8_pipe_top;

    logic clk_in     = 1'b0;
    logic reset_n_in = 1'b1;

    always #5 clk_in = ~clk_in;

    risc8_pipe_top #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    typedef enum {M_NOP, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SHL, M_SHR,
                  M_ADDI, M_LD, M_ST, M_BEQ, M_BNE, M_JMP} mop_e;
    typedef struct {mop_e op; int rd; int rs1; int rs2; int imm;} asm_t;

    asm_t prog [0:10];
    int   model_wr[$];
    int   model_reg[8];
    int   model_mem[256];

    // Executes the program one instruction at a time until it jumps to itself
    function automatic void run_model();
        int   r[8];
        int   pcm;
        int   nxt;
        int   res;
        bit   done;
        asm_t ins;
        for (int i = 0; i < 8; i++) r[i] = 0;
        for (int i = 0; i < 256; i++) model_mem[i] = 0;
        model_wr.delete();
        pcm  = 0;
        done = 0;
        for (int step = 0; step < 500 && !done; step++) begin
            ins = (pcm <= 10) ? prog[pcm] : '{M_NOP, 0, 0, 0, 0};
            nxt = (pcm + 1) % 256;
            res = -1;
            case (ins.op)
                M_ADD:  res = (r[ins.rs1] + r[ins.rs2]) & 255;
                M_SUB:  res = (r[ins.rs1] - r[ins.rs2]) & 255;
                M_AND:  res = r[ins.rs1] & r[ins.rs2];
                M_OR:   res = r[ins.rs1] | r[ins.rs2];
                M_XOR:  res = r[ins.rs1] ^ r[ins.rs2];
                M_SHL:  res = (r[ins.rs1] << (r[ins.rs2] % 8)) & 255;
                M_SHR:  res = r[ins.rs1] >> (r[ins.rs2] % 8);
                M_ADDI: res = (r[ins.rs1] + ins.imm) & 255;
                M_LD:   res = model_mem[(r[ins.rs1] + ins.imm) & 255];
                M_ST:   model_mem[(r[ins.rs1] + ins.imm) & 255] = r[ins.rd];
                M_BEQ:  if (r[ins.rd] == r[ins.rs1]) nxt = (pcm + 1 + ins.imm) & 255;
                M_BNE:  if (r[ins.rd] != r[ins.rs1]) nxt = (pcm + 1 + ins.imm) & 255;
                M_JMP:  begin
                    if (ins.imm == pcm) done = 1;
                    nxt = ins.imm;
                end
                default: ;
            endcase
            if (res >= 0 && ins.rd != 0) begin
                r[ins.rd] = res;
                model_wr.push_back(ins.rd * 256 + res);
            end
            pcm = nxt;
        end
        for (int i = 0; i < 8; i++) model_reg[i] = r[i];
    endfunction

    // ---------------- writeback monitor ----------------
    int wb_q[$];

    always @(negedge clk_in) begin
        if (dut.reset_n === 1'b1 && dut.wb_regwrite === 1'b1 && dut.wb_rd != 3'd0)
            wb_q.push_back(int'({dut.wb_rd, dut.writeback_data}));
    end

    // ---------------- cycle table for the default program ----------------
    typedef struct {
        int cyc; int pc; int stall; int bt;
        int chk_fwd; int fa; int fb;
        int wbw; int wrd; int wdata;
        int memw; int memr; int maddr; int mdata;
    } vec_t;

    vec_t vecs [0:10];
    int   cyc;
    int   exp_final [0:7];
    int   bt_cnt;
    int   n_before;

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic compare_stream(input string tag, input int n);
        for (int j = 0; j < n; j++) begin
            if (j < model_wr.size() && j < wb_q.size())
                check($sformatf("%s_wb%0d", tag, j), wb_q[j], model_wr[j]);
        end
    endtask

    initial begin
        prog[0]  = '{M_ADDI, 1, 0, 0, 5};
        prog[1]  = '{M_ADDI, 2, 0, 0, 3};
        prog[2]  = '{M_ADD,  3, 1, 2, 0};
        prog[3]  = '{M_SUB,  4, 3, 1, 0};
        prog[4]  = '{M_ST,   3, 0, 0, 2};
        prog[5]  = '{M_LD,   5, 0, 0, 2};
        prog[6]  = '{M_ADD,  6, 5, 1, 0};
        prog[7]  = '{M_BEQ,  4, 2, 0, 1};
        prog[8]  = '{M_ADDI, 7, 0, 0, 1};
        prog[9]  = '{M_ADDI, 7, 0, 0, 7};
        prog[10] = '{M_JMP,  0, 0, 0, 10};
        run_model();

        //            cyc pc st bt cf fa fb wbw rd data  mw mr addr data
        vecs[0]  = '{ 0,  0, 0, 0, 1, 0, 0, 0,  0, 0,    0, 0, 0, 0};
        vecs[1]  = '{ 4,  4, 0, 0, 1, 1, 2, 1,  1, 5,    0, 0, 0, 0};
        vecs[2]  = '{ 5,  5, 0, 0, 1, 2, 0, 1,  2, 3,    0, 0, 0, 0};
        vecs[3]  = '{ 6,  6, 0, 0, 1, 0, 1, 1,  3, 8,    0, 0, 0, 0};
        vecs[4]  = '{ 7,  7, 1, 0, 0, 0, 0, 1,  4, 3,    1, 0, 2, 8};
        vecs[5]  = '{ 8,  7, 0, 0, 0, 0, 0, 0,  0, 0,    0, 1, 2, 0};
        vecs[6]  = '{ 9,  8, 0, 0, 1, 1, 0, 1,  5, 8,    0, 0, 0, 0};
        vecs[7]  = '{10,  9, 0, 1, 1, 0, 0, 0,  0, 0,    0, 0, 0, 0};
        vecs[8]  = '{11,  9, 0, 0, 0, 0, 0, 1,  6, 13,   0, 0, 0, 0};
        vecs[9]  = '{14, 12, 0, 1, 0, 0, 0, 0,  0, 0,    0, 0, 0, 0};
        vecs[10] = '{15, 10, 0, 0, 0, 0, 0, 1,  7, 7,    0, 0, 0, 0};

        exp_final = '{8'h00, 8'h05, 8'h03, 8'h08, 8'h03, 8'h08, 8'h0D, 8'h07};

        // Reset held for 5 cycles
        #2 reset_n_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        check("rst_reset_n", dut.reset_n, 0);
        check("rst_pc", dut.pc, 0);
        check("rst_id_instr", dut.id_instr, 0);
        check("rst_ex_rd", dut.ex_rd, 0);
        check("rst_wb_regwrite", dut.wb_regwrite, 0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_R%0d", i), dut.RF.regs[i], 0);

        // Release: synchronized reset rises on the second edge
        @(negedge clk_in) reset_n_in = 1'b1;
        @(posedge clk_in); #1;
        check("rel_edge1_reset_n", dut.reset_n, 0);
        check("rel_edge1_pc", dut.pc, 0);
        @(posedge clk_in); #1;
        check("rel_edge2_reset_n", dut.reset_n, 1);
        cyc = 0;

        // Cycle-accurate table for the default program
        for (int i = 0; i <= 10; i++) begin
            while (cyc < vecs[i].cyc) step();
            check($sformatf("c%0d_pc", cyc), dut.pc, vecs[i].pc);
            check($sformatf("c%0d_stall", cyc), dut.stall, vecs[i].stall);
            check($sformatf("c%0d_branch_taken", cyc), dut.branch_taken, vecs[i].bt);
            check($sformatf("c%0d_flush_ifid", cyc), dut.flush_ifid, vecs[i].bt);
            check($sformatf("c%0d_wb_regwrite", cyc), dut.wb_regwrite, vecs[i].wbw);
            check($sformatf("c%0d_mem_memwrite", cyc), dut.mem_memwrite, vecs[i].memw);
            check($sformatf("c%0d_mem_memread", cyc), dut.mem_memread, vecs[i].memr);
            if (vecs[i].chk_fwd != 0) begin
                check($sformatf("c%0d_forwardA", cyc), dut.forwardA, vecs[i].fa);
                check($sformatf("c%0d_forwardB", cyc), dut.forwardB, vecs[i].fb);
            end
            if (vecs[i].wbw != 0) begin
                check($sformatf("c%0d_wb_rd", cyc), dut.wb_rd, vecs[i].wrd);
                check($sformatf("c%0d_writeback_data", cyc), dut.writeback_data, vecs[i].wdata);
            end
            if (vecs[i].memw != 0 || vecs[i].memr != 0)
                check($sformatf("c%0d_mem_alu_y", cyc), dut.mem_alu_y, vecs[i].maddr);
            if (vecs[i].memw != 0)
                check($sformatf("c%0d_mem_rd2", cyc), dut.mem_rd2, vecs[i].mdata);
        end

        // Halt loop: final architectural state after 60 cycles
        while (cyc < 60) step();
        for (int i = 0; i < 8; i++) check($sformatf("final_R%0d", i), dut.RF.regs[i], exp_final[i]);
        check("final_dmem2", dut.r_dmem[2], 8'h08);
        check("final_wb_count", wb_q.size(), model_wr.size());
        compare_stream("final", model_wr.size());
        n_before = wb_q.size();
        bt_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (dut.branch_taken === 1'b1) bt_cnt++;
        end
        check("halt_branch_count", bt_cnt, 3);
        check("halt_no_writeback", wb_q.size(), n_before);
        check("halt_pc_range", (dut.pc >= 8'd10 && dut.pc <= 8'd12), 1);

        // Random asynchronous reset injection, then a full rerun vs the model
        for (int it = 0; it < 8; it++) begin
            int run_cycles;
            int hold;
            run_cycles = $urandom_range(3, 45);
            repeat (run_cycles) @(posedge clk_in);
            #($urandom_range(1, 8));
            n_before = wb_q.size();
            if (n_before > model_wr.size()) n_before = model_wr.size() + 1;
            check($sformatf("it%0d_prefix_len_ok", it), (wb_q.size() <= model_wr.size()), 1);
            compare_stream($sformatf("it%0d_pre", it), wb_q.size());
            reset_n_in = 1'b0;
            #1;
            check($sformatf("it%0d_async_reset_n", it), dut.reset_n, 0);
            check($sformatf("it%0d_async_pc", it), dut.pc, 0);
            check($sformatf("it%0d_async_R3", it), dut.RF.regs[3], 0);
            check($sformatf("it%0d_async_dmem2", it), dut.r_dmem[2], 0);
            hold = $urandom_range(1, 5);
            repeat (hold) @(posedge clk_in);
            wb_q.delete();
            @(negedge clk_in) reset_n_in = 1'b1;
            repeat (2) @(posedge clk_in);
            #1;
            check($sformatf("it%0d_release", it), dut.reset_n, 1);
            repeat (40) @(posedge clk_in);
            #1;
            check($sformatf("it%0d_wb_count", it), wb_q.size(), model_wr.size());
            compare_stream($sformatf("it%0d", it), model_wr.size());
            for (int i = 0; i < 8; i++)
                check($sformatf("it%0d_R%0d", it, i), dut.RF.regs[i], model_reg[i]);
            check($sformatf("it%0d_dmem2", it), dut.r_dmem[2], model_mem[2]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/risc8_pipe_top.md
Name: risc8_pipe_top

Overview:
- Top level of an 8-bit, 5-stage (IF/ID/EX/MEM/WB) pipelined RISC processor for FPGA.
- Contains clock buffer, reset synchronizer, PC, instruction ROM, 8x8 register file, ALU, forwarding unit, hazard/flush unit, 256x8 data RAM and the pipeline registers.
- Has no data ports. Verification observes it through the internal signal names listed under Behaviour.

Parameters:
- IMEM_DEPTH, 256, instruction ROM words (16-bit each).
- DMEM_DEPTH, 256, data RAM bytes.

Ports:
- clk_in  input  1  single system clock; feeds an internal buffer whose output is net clk.
- reset_n_in  input  1  asynchronous, active-low reset.

Behaviour:
- Reset: two-flop synchronizer produces reset_n. It asserts asynchronously and deasserts on the 2nd clk edge after reset_n_in rises.
- While reset_n=0: PC=0, all pipeline registers hold a NOP (all-zero, control bits 0), all RF registers=0 and data RAM=0.
- Encoding: opcode[15:12], rd[11:9], rs1[8:6], rs2[5:3], imm6[5:0] (sign-extended), jump target[7:0].
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR (shift R[rs1] by R[rs2][2:0]), 8 ADDI, 9 LD, A ST, B BEQ, C BNE, D JMP, E/F NOP.
- ADDI: rd=rs1+imm.
- LD: rd=mem[rs1+imm].
- ST: mem[rs1+imm]=R[rd].
- BEQ/BNE: compare R[rd] with R[rs1]; target=PC_of_branch+1+imm.
- JMP: PC=target.
- Arithmetic: 8-bit wrap-around; no flags.
- PC: 8-bit, increments by 1 per cycle and wraps 0xFF->0x00.
- ROM: combinational read; default contents are the program defined in Test Plan.
- Register file: instance RF, array regs[0:7]. R0 reads 0 and ignores writes. Writes occur on the clk edge in WB; a same-cycle read of the register being written returns the new value.
- Forwarding: forwardA/forwardB are 2 bits each.
  - 10 = from EX/MEM ALU result, which has priority.
  - 01 = from MEM/WB writeback_data.
  - 00 = register file.
  - Never forward from rd=0.
  - Second source is rs2 for R-type, rd field for ST/BEQ/BNE.
- Load-use hazard: an ID instruction reads the rd of an LD currently in EX.
  - stall=1 for exactly 1 cycle.
  - PC and IF/ID hold; a bubble is inserted into ID/EX.
- Branch/jump: resolved in EX.
  - branch_taken=1 loads PC with the target.
  - flush_ifid=1 turns IF/ID and ID/EX into NOPs, for a 2-cycle penalty.
  - branch_taken has priority over stall in the same cycle.
- Memory: data RAM write is synchronous in MEM when mem_memwrite=1; read is combinational on mem_alu_y.
- writeback_data = load data if LD, else the ALU result.
- Latency: result is written to RF 4 cycles after the instruction is fetched.
- Required internal net names (verification probes these hierarchically): clk, reset_n, pc, instr, id_instr, opcode, rs1, rs2, rd, stall, flush_ifid, branch_taken, ex_aluop, ex_rd, alu_y_pipe, forwardA, forwardB, mem_alu_y, mem_rd, mem_rd2 (store data), mem_memread, mem_memwrite, wb_rd, wb_regwrite, writeback_data.

Decomposition:
- Package risc8_pkg: opcode constants, ALU-op encodings, forward-select encodings, NOP instruction constant, instruction field positions.
- One natural sub-module: risc8_regfile (instance RF), 8x8, two async read ports, one sync write port, write bypass.
- Everything else stays in the top.

Test Plan:
- Default program, addresses 0-10:
  - 0: ADDI R1,R0,5
  - 1: ADDI R2,R0,3
  - 2: ADD R3,R1,R2
  - 3: SUB R4,R3,R1
  - 4: ST R3,[R0+2]
  - 5: LD R5,[R0+2]
  - 6: ADD R6,R5,R1
  - 7: BEQ R4,R2,+1
  - 8: ADDI R7,R0,1
  - 9: ADDI R7,R0,7
  - 10: JMP 10
- Reset: hold reset_n_in=0 for 5 cycles -> pc=0, all regs 0. After release, reset_n rises 2 edges later and pc starts counting.
- Forwarding: ADD R3 at address 2 uses EX/MEM and MEM/WB forwarding -> R3=0x08, R4=0x03, no stall.
- Store/load: MEM WRITE at addr 0x02 with data 0x08, then MEM READ at addr 0x02 -> R5=0x08.
- Load-use: ADD R6 -> stall=1 for one cycle, then R6=0x0D.
- Branch: BEQ taken (3==3) -> branch_taken=1, flush_ifid=1. The instruction at address 8 never writes back; R7=0x07.
- Halt loop: after 60 cycles the final state is R0..R7 = 00,05,03,08,03,08,0D,07. pc cycles at 10 with periodic flushes, and no further writebacks occur except none to R0.
